// File: rtl/btn_bcd_counter_display.sv
// 4-digit BCD up/down counter driven by debounced pulses, scanned onto a
// common-anode seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module btn_bcd_counter_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc_pulse,
    input  logic        dec_pulse,
    input  logic        clr_pulse,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       digit_s;
    logic             blank_s;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next count and wrap flag, clear taking priority over simultaneous inc/dec
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_pulse) begin
            cnt_d = 16'h0000;
        end else if (inc_pulse && dec_pulse) begin
            cnt_d = cnt_q;
        end else if (inc_pulse) begin
            cnt_d  = bcd_inc(cnt_q);
            wrap_d = (cnt_q == 16'h9999);
        end else if (dec_pulse) begin
            cnt_d  = bcd_dec(cnt_q);
            wrap_d = (cnt_q == 16'h0000);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Refresh divider and digit index; an tracks the next index so it lands with idx
    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        idx_d     = idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = {CNT_W{1'b0}};
            idx_d     = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
        case (idx_d)
            2'd0:    an_d = 4'b1110;
            2'd1:    an_d = 4'b1101;
            2'd2:    an_d = 4'b1011;
            2'd3:    an_d = 4'b0111;
            default: an_d = 4'b1110;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= 16'h0000;
            wrap_q    <= 1'b0;
            refresh_q <= {CNT_W{1'b0}};
            idx_q     <= 2'd0;
            an_q      <= 4'b1110;
        end else begin
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
        end
    end

    // Segment decode of the scanned digit, straight from registers
    always_comb begin
        digit_s = cnt_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    blank_s = (cnt_q[15:4]  == 12'h000);
            2'd2:    blank_s = (cnt_q[15:8]  == 8'h00);
            2'd3:    blank_s = (cnt_q[15:12] == 4'h0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            seg = 7'b1111111;
        end else begin
            seg = seg_decode(digit_s);
        end
    end

    assign count_bcd = cnt_q;
    assign wrap      = wrap_q;
    assign an        = an_q;
    assign dp        = 1'b1;

endmodule
